// File: rtl/lfsr_encrypt_engine.sv
// Transmit-side LFSR encryptor: writes a PAD_CHAR preamble followed by the plaintext,
// each character XORed with a 6-bit maximal-length LFSR stream, one character per clock.
module lfsr_encrypt_engine #(
  parameter int unsigned N        = 64,
  parameter logic [7:0]  MSG_BASE = 8'd0,
  parameter logic [7:0]  ENC_BASE = 8'd64,
  parameter logic [7:0]  PAD_CHAR = 8'h5F
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  input  logic [2:0] tap_sel,
  input  logic [5:0] seed,
  input  logic [3:0] pre_len,
  output logic [7:0] raddr,
  input  logic [7:0] data_in,
  output logic       wr_en,
  output logic [7:0] waddr,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic [7:0]  raddr_q;
  logic [7:0]  waddr_q;
  logic        wr_en_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [5:0]  lfsr_q;
  logic [6:0]  k_q;
  logic [5:0]  taps_q;
  logic [3:0]  preLen_q;

  logic [5:0]  reqTaps;
  logic        reqOk;
  logic [6:0]  kNext;
  logic [6:0]  preLen7;
  logic [5:0]  lfsrNext;
  logic [7:0]  raddrNext;
  logic        lastChar;
  logic [7:0]  plain;

  always_comb begin
    reqTaps = 6'h21;
    case (tap_sel)
      3'd0:    reqTaps = 6'h21;
      3'd1:    reqTaps = 6'h2D;
      3'd2:    reqTaps = 6'h30;
      3'd3:    reqTaps = 6'h33;
      3'd4:    reqTaps = 6'h36;
      3'd5:    reqTaps = 6'h39;
      default: reqTaps = 6'h21;
    endcase
  end

  assign reqOk = (tap_sel <= 3'd5) && (seed != 6'd0) &&
                 (pre_len >= 4'd7) && (pre_len <= 4'd12);

  assign preLen7  = {3'b000, preLen_q};
  assign kNext    = k_q + 7'd1;
  assign lfsrNext = {lfsr_q[4:0], ^(lfsr_q & taps_q)};
  assign lastChar = (k_q == 7'(N - 1));

  // Read address runs one character ahead so data_in lines up with the next write.
  assign raddrNext = (kNext >= preLen7) ? (MSG_BASE + {1'b0, kNext - preLen7}) : MSG_BASE;

  assign plain    = (k_q < preLen7) ? PAD_CHAR : data_in;
  assign data_out = wr_en_q ? (plain ^ {2'b00, lfsr_q}) : 8'h00;

  assign raddr = raddr_q;
  assign waddr = waddr_q;
  assign wr_en = wr_en_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q  <= IDLE;
      raddr_q  <= 8'd0;
      waddr_q  <= 8'd0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      lfsr_q   <= 6'd0;
      k_q      <= 7'd0;
      taps_q   <= 6'd0;
      preLen_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (reqOk) begin
              taps_q   <= reqTaps;
              preLen_q <= pre_len;
              lfsr_q   <= seed;
              k_q      <= 7'd0;
              state_q  <= RUN;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              err_q    <= 1'b0;
              wr_en_q  <= 1'b1;
              waddr_q  <= ENC_BASE;
              raddr_q  <= MSG_BASE;
            end else begin
              err_q   <= 1'b1;
              done_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        RUN: begin
          k_q     <= kNext;
          lfsr_q  <= lfsrNext;
          waddr_q <= ENC_BASE + {1'b0, kNext};
          raddr_q <= raddrNext;
          if (lastChar) begin
            state_q <= DONE;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Self-checking bench for lfsr_encrypt_engine: a queue of expected writes built from the
// encryption rules is compared against every write, plus literal and decryption checks.
module tb_lfsr_encrypt_engine;

  logic       clk = 1'b0;
  logic       init_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] tap_sel = 3'd0;
  logic [5:0] seed = 6'd1;
  logic [3:0] pre_len = 4'd7;
  logic [7:0] raddr;
  logic [7:0] data_in;
  logic       wr_en;
  logic [7:0] waddr;
  logic [7:0] data_out;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] mem [256];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] raddr;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;
  int   writes = 0;

  lfsr_encrypt_engine dut (
    .clk     (clk),
    .init_n  (init_n),
    .start   (start),
    .tap_sel (tap_sel),
    .seed    (seed),
    .pre_len (pre_len),
    .raddr   (raddr),
    .data_in (data_in),
    .wr_en   (wr_en),
    .waddr   (waddr),
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Combinational-read, clocked-write memory shared by plaintext and ciphertext.
  assign data_in = mem[raddr];
  always @(posedge clk) if (wr_en) mem[waddr] <= data_out;

  task automatic checkOutput(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] tapOf(input int sel);
    logic [5:0] t [6] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};
    return t[sel];
  endfunction

  // Shift left, feedback bit = parity of the tapped bits.
  function automatic logic [5:0] stepLfsr(input logic [5:0] s, input logic [5:0] t);
    int par;
    par = $countones(s & t) % 2;
    return 6'((int'(s) * 2 + par) % 64);
  endfunction

  task automatic buildExpected(input int tap, input logic [5:0] sd, input int pl);
    logic [5:0] s;
    exp_t e;
    s = sd;
    for (int k = 0; k < 64; k++) begin
      e.addr  = 8'(64 + k);
      e.raddr = (k < pl) ? 8'd0 : 8'(k - pl);
      e.data  = ((k < pl) ? 8'h5F : mem[k - pl]) ^ {2'b00, s};
      expQ.push_back(e);
      s = stepLfsr(s, tapOf(tap));
    end
  endtask

  task automatic applyStimulus(input logic [2:0] tap, input logic [5:0] sd, input logic [3:0] pl);
    @(negedge clk);
    tap_sel = tap;
    seed    = sd;
    pre_len = pl;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int base, input int expCyc);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 cyc++;
      if (done) break;
    end
    if (expCyc > 0) checkOutput({name, " done latency"}, cyc, expCyc);
    checkOutput({name, " done"}, int'(done), 1);
    checkOutput({name, " busy"}, int'(busy), 0);
    checkOutput({name, " write count"}, writes - base, 64);
    checkOutput({name, " leftover expected"}, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic waitWrites(input int base, input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (writes - base >= n) return;
    end
    checkOutput("wait for writes timeout", writes - base, n);
  endtask

  // Single compare process: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (init_n === 1'b1) begin
      if (wr_en) begin
        writes++;
        if (expQ.size() == 0) checkOutput("unexpected write", 1, 0);
        else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("waddr", int'(waddr), int'(e.addr));
          checkOutput("data_out", int'(data_out), int'(e.data));
          checkOutput("raddr", int'(raddr), int'(e.raddr));
        end
      end else begin
        checkOutput("data_out idle", int'(data_out), 0);
      end
    end
  end

  initial begin
    int base;
    logic [5:0] s;
    logic [2:0] rt;
    logic [5:0] rs;
    logic [3:0] rp;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h41;

    #3;
    checkOutput("reset wr_en", int'(wr_en), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset err", int'(err), 0);
    checkOutput("reset raddr", int'(raddr), 0);
    checkOutput("reset waddr", int'(waddr), 0);
    checkOutput("reset data_out", int'(data_out), 0);
    repeat (2) @(negedge clk);
    init_n = 1'b1;

    // Basic run with literal pins on the first three characters
    base = writes;
    buildExpected(0, 6'h01, 7);
    applyStimulus(3'd0, 6'h01, 4'd7);
    waitDone("run1", base, 64);
    checkOutput("run1 mem64", int'(mem[64]), 8'h5E);
    checkOutput("run1 mem65", int'(mem[65]), 8'h5C);
    checkOutput("run1 mem66", int'(mem[66]), 8'h58);

    base = writes;
    buildExpected(3, 6'h3F, 10);
    applyStimulus(3'd3, 6'h3F, 4'd10);
    waitDone("run2", base, 64);
    checkOutput("run2 mem64", int'(mem[64]), 8'h60);
    checkOutput("run2 mem74", int'(mem[74]), 8'h63);

    // Illegal requests
    base = writes;
    applyStimulus(3'd0, 6'h00, 4'd7);
    checkOutput("seed0 err", int'(err), 1);
    checkOutput("seed0 done cleared", int'(done), 0);
    repeat (3) @(negedge clk);
    checkOutput("seed0 busy", int'(busy), 0);
    applyStimulus(3'd6, 6'h11, 4'd8);
    checkOutput("tap6 err", int'(err), 1);
    repeat (3) @(negedge clk);
    checkOutput("tap6 busy", int'(busy), 0);
    applyStimulus(3'd2, 6'h11, 4'd6);
    checkOutput("pre6 err", int'(err), 1);
    repeat (3) @(negedge clk);
    checkOutput("pre6 busy", int'(busy), 0);
    applyStimulus(3'd2, 6'h11, 4'd13);
    checkOutput("pre13 err", int'(err), 1);
    repeat (3) @(negedge clk);
    checkOutput("illegal writes", writes - base, 0);

    base = writes;
    buildExpected(2, 6'h11, 8);
    applyStimulus(3'd2, 6'h11, 4'd8);
    checkOutput("legal clears err", int'(err), 0);
    checkOutput("legal busy", int'(busy), 1);
    waitDone("run3", base, 64);

    // Start during a run must be ignored
    base = writes;
    buildExpected(1, 6'h15, 9);
    applyStimulus(3'd1, 6'h15, 4'd9);
    waitWrites(base, 20);
    tap_sel = 3'd4;
    seed    = 6'h3A;
    pre_len = 4'd12;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("midstart", base, 0);

    // Asynchronous reset mid-run
    base = writes;
    buildExpected(2, 6'h0B, 8);
    applyStimulus(3'd2, 6'h0B, 4'd8);
    waitWrites(base, 30);
    #2 init_n = 1'b0;
    #1;
    checkOutput("midreset wr_en", int'(wr_en), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset data_out", int'(data_out), 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);
    checkOutput("postreset busy", int'(busy), 0);
    checkOutput("postreset done", int'(done), 0);
    checkOutput("postreset wr_en", int'(wr_en), 0);
    base = writes;
    buildExpected(5, 6'h27, 11);
    applyStimulus(3'd5, 6'h27, 4'd11);
    waitDone("postreset run", base, 64);

    // Every tap pattern decrypts back to preamble + plaintext
    for (int t = 0; t < 6; t++) begin
      base = writes;
      buildExpected(t, 6'h2A, 12);
      applyStimulus(3'(t), 6'h2A, 4'd12);
      waitDone($sformatf("tap%0d", t), base, 64);
      s = 6'h2A;
      for (int k = 0; k < 64; k++) begin
        checkOutput($sformatf("tap%0d decrypt k%0d", t, k), int'(mem[64 + k] ^ {2'b00, s}),
                    (k < 12) ? 8'h5F : int'(mem[k - 12]));
        s = stepLfsr(s, tapOf(t));
      end
    end

    // Random legal runs
    for (int r = 0; r < 4; r++) begin
      rt = 3'($urandom_range(0, 5));
      rs = 6'($urandom_range(1, 63));
      rp = 4'($urandom_range(7, 12));
      base = writes;
      buildExpected(int'(rt), rs, int'(rp));
      applyStimulus(rt, rs, rp);
      waitDone($sformatf("random%0d", r), base, 64);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
